eth_hdr_capture_ctrl: RTL and testbench

Sequencer that sits in front of `eth_header_parser`. It accepts an 8-bit valid/ready byte stream of Ethernet frames and assembles the first 14 bytes into the packed `header_bytes` vector. It presents that vector with `header_valid` and holds it until the downstream consumer acknowledges. It then passes the remaining payload bytes through to a downstream byte stream.

---
 rtl/eth_hdr_capture_ctrl_if.sv | 27 ++
 rtl/eth_hdr_capture_ctrl.sv | 163 ++++++++++++++++
 tb/tb_eth_hdr_capture_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_hdr_capture_ctrl_if.sv
// Byte-stream, header hand-off and payload signals of eth_hdr_capture_ctrl.
// The master side is the frame source and consumer; the slave side is the sequencer.
interface eth_hdr_capture_ctrl_if #(
   parameter int HDR_BYTES = 14
);
   logic [7:0]             s_data;
   logic                   s_valid;
   logic                   s_last;
   logic                   s_ready;
   logic [HDR_BYTES*8-1:0] header_bytes;
   logic                   header_valid;
   logic                   header_ack;
   logic [7:0]             m_data;
   logic                   m_valid;
   logic                   m_last;
   logic                   m_ready;

   modport master (
      output s_data, s_valid, s_last, header_ack, m_ready,
      input  s_ready, header_bytes, header_valid, m_data, m_valid, m_last
   );

   modport slave (
      input  s_data, s_valid, s_last, header_ack, m_ready,
      output s_ready, header_bytes, header_valid, m_data, m_valid, m_last
   );
endinterface

// File: rtl/eth_hdr_capture_ctrl.sv
// Captures the Ethernet header from a byte stream, holds it for the parser until acked,
// then passes the payload through. Optional runt reporting: define ETH_RUNT_CHECK_EN.
module eth_hdr_capture_ctrl #(
   parameter int HDR_BYTES = 14,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   eth_hdr_capture_ctrl_if.slave bus,
   output logic [CNT_W-1:0]      frame_count,
   output logic                  runt_err,
   output logic [CNT_W-1:0]      runt_count
);
   localparam logic [3:0] LAST_IDX = 4'(HDR_BYTES - 1);

   typedef enum logic [1:0] {
      ST_CAPTURE = 2'd0,
      ST_HOLD    = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_t;

   state_t                 state_r;
   state_t                 state_s;
   logic [3:0]             idx_r;
   logic                   hdr_only_r;
   logic [HDR_BYTES*8-1:0] header_bytes_r;
   logic                   header_valid_r;
   logic [CNT_W-1:0]       frame_count_r;
   logic                   cap_xfer_s;
   logic                   ack_s;
   logic                   s_ready_s;
   logic                   m_valid_s;
   logic                   m_last_s;
   logic [7:0]             m_data_s;

   assign cap_xfer_s = (state_r == ST_CAPTURE) && bus.s_valid;
   assign ack_s      = (state_r == ST_HOLD) && bus.header_ack;

   // Next-state decode and the stream-side handshake outputs
   always_comb begin
      state_s   = state_r;
      s_ready_s = 1'b0;
      m_valid_s = 1'b0;
      m_last_s  = 1'b0;
      m_data_s  = 8'h00;
      case (state_r)
         ST_CAPTURE: begin
            s_ready_s = 1'b1;
            if (cap_xfer_s && (idx_r == LAST_IDX)) begin
               state_s = ST_HOLD;
            end else begin
               state_s = ST_CAPTURE;
            end
         end
         ST_HOLD: begin
            if (ack_s) begin
               state_s = hdr_only_r ? ST_CAPTURE : ST_PAYLOAD;
            end else begin
               state_s = ST_HOLD;
            end
         end
         ST_PAYLOAD: begin
            // Zero-latency pass-through; backpressure flows straight back to the source
            s_ready_s = bus.m_ready;
            m_valid_s = bus.s_valid;
            m_last_s  = bus.s_last;
            m_data_s  = bus.s_data;
            if (bus.s_valid && bus.m_ready && bus.s_last) begin
               state_s = ST_CAPTURE;
            end else begin
               state_s = ST_PAYLOAD;
            end
         end
         default: begin
            state_s = ST_CAPTURE;
         end
      endcase
   end

   // State register and the header-valid flag that tracks entry into HOLD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_CAPTURE;
         header_valid_r <= 1'b0;
      end else begin
         state_r        <= state_s;
         header_valid_r <= (state_s == ST_HOLD);
      end
   end

   // Header byte assembly; a runt or a completed header rewinds the byte index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r          <= 4'd0;
         hdr_only_r     <= 1'b0;
         header_bytes_r <= {(HDR_BYTES*8){1'b0}};
      end else if (cap_xfer_s) begin
         for (int k = 0; k < HDR_BYTES; k++) begin
            if (idx_r == 4'(k)) begin
               header_bytes_r[k*8 +: 8] <= bus.s_data;
            end
         end
         if (idx_r == LAST_IDX) begin
            idx_r      <= 4'd0;
            hdr_only_r <= bus.s_last;
         end else if (bus.s_last) begin
            idx_r      <= 4'd0;
         end else begin
            idx_r      <= idx_r + 4'd1;
         end
      end else begin
         idx_r <= idx_r;
      end
   end

   // Acknowledged-header counter, wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_count_r <= {CNT_W{1'b0}};
      end else if (ack_s) begin
         frame_count_r <= frame_count_r + CNT_W'(1'b1);
      end else begin
         frame_count_r <= frame_count_r;
      end
   end

`ifdef ETH_RUNT_CHECK_EN
   logic             runt_s;
   logic             runt_err_r;
   logic [CNT_W-1:0] runt_count_r;

   assign runt_s = cap_xfer_s && bus.s_last && (idx_r != LAST_IDX);

   // Runt pulse and saturating runt counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         runt_err_r   <= 1'b0;
         runt_count_r <= {CNT_W{1'b0}};
      end else begin
         runt_err_r <= runt_s;
         if (runt_s && (runt_count_r != {CNT_W{1'b1}})) begin
            runt_count_r <= runt_count_r + CNT_W'(1'b1);
         end else begin
            runt_count_r <= runt_count_r;
         end
      end
   end

   assign runt_err   = runt_err_r;
   assign runt_count = runt_count_r;
`else
   assign runt_err   = 1'b0;
   assign runt_count = {CNT_W{1'b0}};
`endif

   assign bus.s_ready      = s_ready_s;
   assign bus.m_valid      = m_valid_s;
   assign bus.m_last       = m_last_s;
   assign bus.m_data       = m_data_s;
   assign bus.header_bytes = header_bytes_r;
   assign bus.header_valid = header_valid_r;
   assign frame_count      = frame_count_r;
endmodule

// File: tb/tb_eth_hdr_capture_ctrl.sv
// Directed plus randomized frames for eth_hdr_capture_ctrl, checked against a
// frame-level reference model (header = first 14 bytes, payload = the rest).
module tb_eth_hdr_capture_ctrl;
   localparam int HB = 14;
`ifdef ETH_RUNT_CHECK_EN
   localparam bit RUNT_EN = 1'b1;
`else
   localparam bit RUNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] frame_count;
   logic        runt_err;
   logic [15:0] runt_count;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  frm[$];
   logic [15:0] exp_frames;
   logic [15:0] exp_runts;

   eth_hdr_capture_ctrl_if #(.HDR_BYTES(HB)) bus ();

   eth_hdr_capture_ctrl #(.HDR_BYTES(HB), .CNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .frame_count (frame_count),
      .runt_err    (runt_err),
      .runt_count  (runt_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int n, input bit seq);
      frm.delete();
      for (int i = 0; i < n; i++) begin
         if (seq) frm.push_back(8'(i));
         else     frm.push_back(8'($urandom_range(0, 255)));
      end
   endtask

   task automatic check_reset();
      check("rst_hdr_bytes", bus.header_bytes, 0);
      check("rst_hdr_valid", bus.header_valid, 0);
      check("rst_s_ready", bus.s_ready, 1);
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_m_last", bus.m_last, 0);
      check("rst_m_data", bus.m_data, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_runt_err", runt_err, 0);
      check("rst_runt_count", runt_count, 0);
   endtask

   // mode 0: m_ready held high; 1: m_ready toggles; 2: random m_ready and s_valid gaps
   task automatic run_frame(input int ack_delay, input int mode);
      int          n;
      int          pi;
      int          budget;
      logic        tog;
      logic [111:0] exp_hdr;
      logic [7:0]  got_q[$];
      n = frm.size();
      for (int i = 0; i < n && i < HB; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = frm[i];
         bus.s_last  = (i == n - 1);
         #1;
         check("cap_s_ready", bus.s_ready, 1);
         check("cap_m_valid", bus.m_valid, 0);
         check("cap_hdr_valid", bus.header_valid, 0);
         tick();
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      if (n < HB) begin
         if (RUNT_EN && exp_runts != 16'hFFFF) exp_runts++;
         #1;
         check("runt_err_pulse", runt_err, RUNT_EN);
         check("runt_no_hdr", bus.header_valid, 0);
         tick();
         check("runt_err_clear", runt_err, 0);
         check("runt_count", runt_count, exp_runts);
         return;
      end
      for (int k = 0; k < HB; k++) exp_hdr[k*8 +: 8] = frm[k];
      for (int d = 0; d <= ack_delay; d++) begin
         bus.s_valid    = (n > HB);
         bus.s_data     = (n > HB) ? frm[HB] : 8'h00;
         bus.s_last     = (n == HB + 1);
         bus.m_ready    = 1'b1;
         bus.header_ack = (d == ack_delay);
         #1;
         check("hold_hdr_valid", bus.header_valid, 1);
         check("hold_hdr_bytes", bus.header_bytes, exp_hdr);
         check("hold_s_ready", bus.s_ready, 0);
         check("hold_m_valid", bus.m_valid, 0);
         tick();
      end
      bus.header_ack = 1'b0;
      exp_frames++;
      if (n == HB) begin
         bus.s_valid = 1'b0;
         #1;
         check("hdronly_hdr_valid", bus.header_valid, 0);
         check("hdronly_m_valid", bus.m_valid, 0);
         check("hdronly_s_ready", bus.s_ready, 1);
         check("frame_count", frame_count, exp_frames);
         return;
      end
      pi = HB;
      budget = 0;
      tog = 1'b1;
      while (pi < n && budget < 400) begin
         bus.s_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.s_data  = bus.s_valid ? frm[pi] : 8'($urandom_range(0, 255));
         bus.s_last  = bus.s_valid && (pi == n - 1);
         case (mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = tog;
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
         tog = ~tog;
         #1;
         if (budget == 0) begin
            check("pl_hdr_valid_drop", bus.header_valid, 0);
            check("frame_count", frame_count, exp_frames);
         end
         check("pl_m_valid", bus.m_valid, bus.s_valid);
         check("pl_s_ready", bus.s_ready, bus.m_ready);
         if (bus.s_valid) begin
            check("pl_m_data", bus.m_data, frm[pi]);
            check("pl_m_last", bus.m_last, (pi == n - 1));
            if (bus.m_ready) begin
               got_q.push_back(bus.m_data);
               pi++;
            end
         end
         tick();
         budget++;
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      check("pl_done_in_budget", pi, n);
      check("pl_len", got_q.size(), n - HB);
      for (int i = 0; i < got_q.size() && HB + i < n; i++) begin
         check("pl_byte", got_q[i], frm[HB + i]);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.s_data     = 8'h00;
      bus.s_valid    = 1'b0;
      bus.s_last     = 1'b0;
      bus.header_ack = 1'b0;
      bus.m_ready    = 1'b1;
      exp_frames     = 16'd0;
      exp_runts      = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      check_reset();
      rst_n = 1'b1;
      tick();

      // basic 20-byte frame 0x00..0x13, ack on first HOLD cycle
      fill(20, 1'b1);
      run_frame(0, 0);
      // ack held off for 5 HOLD cycles
      fill(18, 1'b0);
      run_frame(5, 0);
      // header-only frame, then a frame whose byte 0 must land at [7:0]
      fill(14, 1'b0);
      run_frame(0, 0);
      fill(16, 1'b0);
      run_frame(1, 0);
      // runt, then a valid 15-byte frame
      fill(6, 1'b0);
      run_frame(0, 0);
      fill(15, 1'b0);
      run_frame(0, 0);
      // toggling backpressure
      fill(24, 1'b0);
      run_frame(2, 1);
      // randomized frames, including runts and header-only lengths
      for (int f = 0; f < 14; f++) begin
         fill($urandom_range(1, 32), 1'b0);
         run_frame($urandom_range(0, 3), 2);
      end

      // reset lands after 8 header bytes
      fill(8, 1'b0);
      for (int i = 0; i < 8; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = frm[i];
         bus.s_last  = 1'b0;
         tick();
      end
      bus.s_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset();
      exp_frames = 16'd0;
      exp_runts  = 16'd0;
      tick();
      rst_n = 1'b1;
      tick();
      fill(17, 1'b0);
      run_frame(0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
